// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer
//   Transmit framer for the RGMII path at 1000 Mb/s (one byte per clk_i).
//   Takes a payload byte stream (destination address through end of payload)
//   and produces a GMII byte stream: preamble, SFD, payload, zero padding up
//   to a minimum length, CRC-32 FCS and an inter-frame gap. Its output feeds
//   the DDR nibble serializer.
//
// Ports
//   clk_i          byte clock, everything on posedge
//   reset_n_i      asynchronous active-low reset
//   data_i         payload byte
//   valid_i        data_i valid
//   last_i         data_i is the final payload byte of the frame
//   ready_o        byte consumed when valid_i & ready_o
//   gmii_txd_o     transmit byte (registered)
//   gmii_tx_en_o   transmit enable (registered)
//   gmii_tx_er_o   transmit error, only on the underrun byte (registered)
//   underrun_o     one-cycle pulse when a frame is aborted by underrun

module rgmii_tx_framer #(
    parameter int preamble_len_p = 7,   // 1..15
    parameter int min_payload_p  = 60,  // 0..63
    parameter int ifg_p          = 12   // 1..31
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       last_i,
    output logic       ready_o,
    output logic [7:0] gmii_txd_o,
    output logic       gmii_tx_en_o,
    output logic       gmii_tx_er_o,
    output logic       underrun_o
);

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN
    } state_t;

    localparam logic [4:0] PRE_LAST = 5'(preamble_len_p - 1);
    localparam logic [4:0] IFG_LAST = 5'(ifg_p - 1);
    localparam logic [5:0] MIN_PAY  = 6'(min_payload_p);

    state_t      state;
    logic [4:0]  cnt;        // preamble index, FCS byte index or IFG cycle
    logic [5:0]  byte_cnt;   // DATA+PAD bytes sent, saturates at 63
    logic [31:0] crc;

    logic [5:0]  byte_cnt_inc;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;

    // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign byte_cnt_inc = (byte_cnt == 6'd63) ? 6'd63 : byte_cnt + 6'd1;
    assign fcs_word     = ~crc;

    // FCS goes out least significant byte first.
    always_comb begin
        fcs_byte = fcs_word[7:0];
        case (cnt[1:0])
            2'd0: fcs_byte = fcs_word[7:0];
            2'd1: fcs_byte = fcs_word[15:8];
            2'd2: fcs_byte = fcs_word[23:16];
            2'd3: fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    // Accepting bytes while sending payload, and discarding the rest of an
    // aborted frame while draining.
    assign ready_o = (state == DATA) || (state == DRAIN);

    // The state names what the next clock edge will put on the wire; every
    // output byte is registered on the edge that leaves/continues that state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            byte_cnt     <= 6'd0;
            crc          <= 32'hFFFF_FFFF;
            gmii_txd_o   <= 8'h00;
            gmii_tx_en_o <= 1'b0;
            gmii_tx_er_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            gmii_tx_er_o <= 1'b0;
            underrun_o   <= 1'b0;
            case (state)
                IDLE: begin
                    gmii_txd_o   <= 8'h00;
                    gmii_tx_en_o <= 1'b0;
                    if (valid_i) begin
                        // First preamble byte goes out on this edge.
                        gmii_txd_o   <= 8'h55;
                        gmii_tx_en_o <= 1'b1;
                        crc          <= 32'hFFFF_FFFF;
                        byte_cnt     <= 6'd0;
                        cnt          <= 5'd0;
                        state        <= (PRE_LAST == 5'd0) ? SFD : PRE;
                    end
                end
                PRE: begin
                    gmii_txd_o   <= 8'h55;
                    gmii_tx_en_o <= 1'b1;
                    cnt          <= cnt + 5'd1;
                    if (cnt + 5'd1 == PRE_LAST) begin
                        state <= SFD;
                    end
                end
                SFD: begin
                    gmii_txd_o   <= 8'hD5;
                    gmii_tx_en_o <= 1'b1;
                    state        <= DATA;
                end
                DATA: begin
                    gmii_tx_en_o <= 1'b1;
                    if (valid_i) begin
                        gmii_txd_o <= data_i;
                        crc        <= crc_byte(crc, data_i);
                        byte_cnt   <= byte_cnt_inc;
                        if (last_i) begin
                            cnt   <= 5'd0;
                            state <= (byte_cnt_inc < MIN_PAY) ? PAD : FCS;
                        end
                    end else begin
                        // Source starved us mid-frame: poison the frame on the
                        // wire and throw away the remainder of it.
                        gmii_txd_o   <= 8'h00;
                        gmii_tx_er_o <= 1'b1;
                        underrun_o   <= 1'b1;
                        state        <= DRAIN;
                    end
                end
                PAD: begin
                    gmii_txd_o   <= 8'h00;
                    gmii_tx_en_o <= 1'b1;
                    crc          <= crc_byte(crc, 8'h00);
                    byte_cnt     <= byte_cnt_inc;
                    if (byte_cnt_inc >= MIN_PAY) begin
                        cnt   <= 5'd0;
                        state <= FCS;
                    end
                end
                FCS: begin
                    gmii_txd_o   <= fcs_byte;
                    gmii_tx_en_o <= 1'b1;
                    cnt          <= cnt + 5'd1;
                    if (cnt[1:0] == 2'd3) begin
                        cnt   <= 5'd0;
                        state <= IFG;
                    end
                end
                IFG: begin
                    gmii_txd_o   <= 8'h00;
                    gmii_tx_en_o <= 1'b0;
                    cnt          <= cnt + 5'd1;
                    if (cnt == IFG_LAST) begin
                        cnt   <= 5'd0;
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    gmii_txd_o   <= 8'h00;
                    gmii_tx_en_o <= 1'b0;
                    if (valid_i && last_i) begin
                        cnt   <= 5'd0;
                        state <= IFG;
                    end
                end
                default: begin
                    gmii_txd_o   <= 8'h00;
                    gmii_tx_en_o <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// tb_rgmii_tx_framer
//   Randomized bench for rgmii_tx_framer. Two instances: one with default
//   parameters and one with no minimum payload (for the "123456789" CRC
//   known-answer frame). Expected wire images are built from the frame rules
//   (preamble, SFD, payload, zero pad, table-driven CRC-32 LSB first).

module tb_rgmii_tx_framer;

    typedef logic [7:0] bq_t[$];

    localparam int PRE_N = 7;
    localparam int MIN_N = 60;
    localparam int IFG_N = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data;
    logic       valid, last, sel;
    logic       valid_a, valid_b, rdy;
    logic       rdy_a, en_a, er_a, un_a;
    logic [7:0] txd_a;
    logic       rdy_b, en_b, er_b, un_b;
    logic [7:0] txd_b;

    assign valid_a = valid & ~sel;
    assign valid_b = valid & sel;
    assign rdy     = sel ? rdy_b : rdy_a;

    rgmii_tx_framer dut (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data), .valid_i(valid_a), .last_i(last),
        .ready_o(rdy_a), .gmii_txd_o(txd_a), .gmii_tx_en_o(en_a), .gmii_tx_er_o(er_a),
        .underrun_o(un_a)
    );

    rgmii_tx_framer #(.min_payload_p(0)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data), .valid_i(valid_b), .last_i(last),
        .ready_o(rdy_b), .gmii_txd_o(txd_b), .gmii_tx_en_o(en_b), .gmii_tx_er_o(er_b),
        .underrun_o(un_b)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] crc_tab [256];

    function automatic logic [31:0] crc32(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ b[i]];
        return ~c;
    endfunction

    // Wire image of one frame; er = index of the tx_er byte or -1.
    function automatic void make_frame(input bq_t pay, input int minp, input int under_at,
                                       output bq_t f, output int er);
        bq_t body;
        logic [31:0] c;
        f.delete();
        er = -1;
        for (int i = 0; i < PRE_N; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        if (under_at >= 0) begin
            for (int i = 0; i < under_at; i++) f.push_back(pay[i]);
            er = f.size();
            f.push_back(8'h00);
            return;
        end
        body = pay;
        while (body.size() < minp) body.push_back(8'h00);
        c = crc32(body);
        foreach (body[i]) f.push_back(body[i]);
        for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
    endfunction

    function automatic bq_t rand_payload(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    bq_t exp_bytes;
    int  exp_len[$];
    int  exp_er[$];

    task automatic push_expected(input bq_t pay, input int under_at);
        bq_t f;
        int  er;
        make_frame(pay, MIN_N, under_at, f, er);
        foreach (f[i]) exp_bytes.push_back(f[i]);
        exp_len.push_back(f.size());
        exp_er.push_back(er);
    endtask

    // ---------------- monitor for the default instance ----------------
    bq_t cap;
    int  cap_er_n = 0, cap_er_pos = -1;
    int  idle_run = 1000, last_gap = -1, last_len = 0, frames_seen = 0;
    int  ready_cnt = 0, un_cnt = 0, er_idle = 0;
    bit  in_frame = 1'b0;

    task automatic end_frame();
        bq_t ef;
        int  len, er, bad;
        frames_seen++;
        last_len = cap.size();
        if (exp_len.size() == 0) begin
            check_eq("unexpected_frame_len", cap.size(), 0);
            return;
        end
        len = exp_len.pop_front();
        er  = exp_er.pop_front();
        for (int i = 0; i < len; i++) if (exp_bytes.size() != 0) ef.push_back(exp_bytes.pop_front());
        check_eq("frame_len", cap.size(), len);
        bad = 0;
        for (int i = 0; i < ef.size(); i++) if (i >= cap.size() || cap[i] !== ef[i]) bad++;
        check_eq("frame_bytes_bad", bad, 0);
        if (er < 0 && cap.size() >= 4 && ef.size() >= 4)
            check_eq("fcs",
                     {cap[cap.size()-1], cap[cap.size()-2], cap[cap.size()-3], cap[cap.size()-4]},
                     {ef[ef.size()-1], ef[ef.size()-2], ef[ef.size()-3], ef[ef.size()-4]});
        check_eq("tx_er_count", cap_er_n, (er < 0) ? 0 : 1);
        check_eq("tx_er_pos", 64'(signed'(cap_er_pos)), 64'(signed'(er)));
        $display("frame %0d: %0d bytes on wire, gap before %0d, tx_er index %0d",
                 frames_seen, cap.size(), last_gap, cap_er_pos);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            cap.delete();
            idle_run = 1000;
        end else begin
            if (rdy_a) ready_cnt++;
            if (un_a) un_cnt++;
            if (en_a) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    last_gap   = idle_run;
                    cap.delete();
                    cap_er_n   = 0;
                    cap_er_pos = -1;
                end
                if (er_a) begin
                    cap_er_n++;
                    cap_er_pos = cap.size();
                end
                cap.push_back(txd_a);
            end else begin
                if (er_a) er_idle++;
                if (in_frame) begin
                    in_frame = 1'b0;
                    idle_run = 0;
                    end_frame();
                end
                idle_run++;
            end
        end
    end

    // ---------------- monitor for the min_payload=0 instance ----------------
    bq_t q0;
    int  gap0 = -1, idle0 = 0, er0 = 0;
    bit  in0 = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (er_b) er0++;
            if (en_b) begin
                if (!in0 && q0.size() != 0) gap0 = idle0;
                in0 = 1'b1;
                q0.push_back(txd_b);
            end else begin
                if (in0) idle0 = 0;
                in0 = 1'b0;
                idle0++;
            end
        end
    end

    // ---------------- driver ----------------
    // Presents pay[] on the handshake; under_at >= 0 drops valid for one
    // cycle after that many bytes were accepted. hold keeps valid high after
    // the last byte so the next frame follows back to back.
    task automatic send_frame(input bq_t pay, input int under_at, input bit hold);
        int i = 0;
        int guard = 0;
        bit dropped = 1'b0;
        valid = 1'b1;
        data  = pay[0];
        last  = (pay.size() == 1);
        while (i < pay.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (i == under_at && !dropped && rdy) begin
                valid = 1'b0;
                @(posedge clk);
                #1;
                valid   = 1'b1;
                dropped = 1'b1;
            end else if (rdy) begin
                @(posedge clk);
                #1;
                i++;
                if (i < pay.size()) begin
                    data = pay[i];
                    last = (i == pay.size() - 1);
                end
            end
        end
        if (guard >= 20000) check_eq("send_timeout", 0, 1);
        if (!hold) begin
            valid = 1'b0;
            last  = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (exp_len.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check_eq({tag, "_timeout"}, 0, 1);
        repeat (IFG_N + 3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bq_t ascii, p1, p2, exp0, f;
        int  er, r0, u0, n, bad;
        logic [31:0] c;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[i] = c;
        end

        rst_n = 1'b0; valid = 1'b0; last = 1'b0; data = 8'h00; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_txd", txd_a, 8'h00);
        check_eq("reset_tx_en", en_a, 1'b0);
        check_eq("reset_tx_er", er_a, 1'b0);
        check_eq("reset_ready", rdy_a, 1'b0);
        check_eq("reset_underrun", un_a, 1'b0);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Known-answer frame on the unpadded instance, sent twice back to back.
        for (int i = 0; i < 9; i++) ascii.push_back(8'h31 + 8'(i));
        check_eq("model_crc_known_answer", crc32(ascii), 32'hCBF4_3926);
        make_frame(ascii, 0, -1, f, er);
        foreach (f[i]) exp0.push_back(f[i]);
        foreach (f[i]) exp0.push_back(f[i]);
        sel = 1'b1;
        send_frame(ascii, -1, 1'b1);
        send_frame(ascii, -1, 1'b0);
        n = 0;
        while (q0.size() < 42 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq("ascii_timeout", 0, 1);
        repeat (IFG_N + 3) @(negedge clk);
        sel = 1'b0;
        check_eq("ascii_wire_len", q0.size(), 42);
        bad = 0;
        for (int i = 0; i < exp0.size(); i++) if (i >= q0.size() || q0[i] !== exp0[i]) bad++;
        check_eq("ascii_bytes_bad", bad, 0);
        if (q0.size() >= 21) check_eq("ascii_fcs", {q0[20], q0[19], q0[18], q0[17]}, 32'hCBF4_3926);
        check_eq("ascii_ifg", gap0, IFG_N);
        $display("ascii frames: %0d bytes on wire, gap %0d", q0.size(), gap0);

        // 10-byte frame, padded to 60.
        r0 = ready_cnt;
        p1 = rand_payload(10);
        push_expected(p1, -1);
        send_frame(p1, -1, 1'b0);
        wait_done("short");
        check_eq("short_tx_en_cycles", last_len, 72);
        check_eq("short_ready_cycles", ready_cnt - r0, 10);

        // Two 64-byte frames with valid held high throughout.
        p1 = rand_payload(64);
        p2 = rand_payload(64);
        push_expected(p1, -1);
        push_expected(p2, -1);
        send_frame(p1, -1, 1'b1);
        send_frame(p2, -1, 1'b0);
        wait_done("b2b");
        check_eq("b2b_ifg", last_gap, IFG_N);

        // Underrun after 5 bytes, then a clean frame.
        u0 = un_cnt;
        p1 = rand_payload(20);
        push_expected(p1, 5);
        send_frame(p1, 5, 1'b0);
        p2 = rand_payload(30);
        push_expected(p2, -1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_frame(p2, -1, 1'b0);
        wait_done("underrun");
        check_eq("underrun_pulses", un_cnt - u0, 1);

        // Random lengths with random idle before each frame.
        for (int fr = 0; fr < 6; fr++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            p1 = rand_payload((fr == 0) ? int'($urandom_range(1, 59)) : int'($urandom_range(1, 1500)));
            push_expected(p1, -1);
            send_frame(p1, -1, 1'b0);
        end
        wait_done("random");

        // Reset in the middle of DATA.
        valid = 1'b1; data = 8'hA5; last = 1'b0;
        n = 0;
        while (!rdy_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("reset_mid_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #1 check_eq("pre_reset_tx_en", en_a, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_reset_txd", txd_a, 8'h00);
        check_eq("mid_reset_tx_en", en_a, 1'b0);
        check_eq("mid_reset_ready", rdy_a, 1'b0);
        check_eq("mid_reset_tx_er", er_a, 1'b0);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        p1 = rand_payload(40);
        push_expected(p1, -1);
        send_frame(p1, -1, 1'b0);
        wait_done("post_reset");

        check_eq("tx_er_outside_frame", er_idle, 0);
        check_eq("tx_er_unpadded_inst", er0, 0);
        check_eq("frames_outstanding", exp_len.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_framer.md
Name: rgmii_tx_framer

Overview:
- Transmit-side framer for the Ethernet RGMII path, opposite direction to the RX input-delay/capture logic.
- Accepts a payload byte stream (destination address through end of payload) over a valid/ready handshake.
- Emits a GMII-style byte stream (txd/tx_en/tx_er) with preamble, SFD, minimum-length padding, FCS (CRC-32) and inter-frame gap.
- Output feeds the DDR nibble serializer; runs at one byte per clk_i (1000 Mb/s mode).

Parameters:
preamble_len_p, 7, number of 0x55 preamble bytes before SFD (1..15)
min_payload_p, 60, minimum bytes before FCS; shorter frames padded with 0x00 (0..63)
ifg_p, 12, idle cycles (tx_en=0) after last FCS byte before next preamble (1..31)

Ports:
clk_i  input  1  byte clock, all logic on posedge
reset_n_i  input  1  asynchronous active-low reset
data_i  input  8  payload byte
valid_i  input  1  data_i valid
last_i  input  1  data_i is final payload byte of frame
ready_o  output  1  byte consumed when valid_i & ready_o
gmii_txd_o  output  8  transmit byte, registered
gmii_tx_en_o  output  1  transmit enable, registered
gmii_tx_er_o  output  1  transmit error, registered
underrun_o  output  1  one-cycle pulse when frame aborted by underrun

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): state=IDLE; gmii_txd_o=0, gmii_tx_en_o=0, gmii_tx_er_o=0, underrun_o=0, ready_o=0, counters=0, CRC=0xFFFFFFFF. Assertion mid-frame truncates output immediately; no error byte emitted.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN.
- IDLE: ready_o=0; valid_i=1 sampled -> PRE (byte not consumed). First 0x55 appears on outputs the next cycle (1-cycle latency, tx_en=1).
- PRE: outputs 0x55 for preamble_len_p cycles total -> SFD. SFD: outputs 0xD5 for one cycle -> DATA.
- DATA: ready_o=1 (combinational from state). Each handshake registers data_i onto txd (tx_en=1), updates CRC, increments byte count (6-bit, saturating at 63).
  - Handshake with last_i=1: -> PAD if count after this byte < min_payload_p, else -> FCS.
  - valid_i=0 in DATA = underrun: that cycle outputs txd=0x00, tx_en=1, tx_er=1; underrun_o pulses; -> DRAIN.
- PAD: outputs 0x00 and updates CRC until count = min_payload_p -> FCS. ready_o=0.
- FCS: 4 cycles outputting ~CRC bytes, LSB byte first; CRC frozen during FCS.
  - CRC: IEEE 802.3 reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, covers DATA+PAD bytes only.
  - CRC and count reinit on entering PRE.
- IFG: tx_en=0, txd=0 for ifg_p cycles -> IDLE. valid_i ignored; ready_o=0.
- DRAIN: tx_en=0, ready_o=1; discards bytes until handshake with last_i=1 -> IFG. Aborted frame is never retried.
- tx_er only ever asserted on the underrun cycle; tx_en=0 in IDLE, IFG, DRAIN.
- Zero-length frame is impossible: first DATA byte always carries payload; last_i on first byte is legal.
- Back-to-back frames: valid_i held high through IFG -> PRE starts the cycle after IFG exits IDLE (IDLE lasts one cycle).

Test Plan:
- min_payload_p=0, send ASCII "123456789" (last on '9') -> txd: 7x0x55, 0xD5, 0x31..0x39, then FCS 0x26,0x39,0xF4,0xCB; tx_en high exactly 21 cycles; then 12 idle cycles.
- Default params, 10-byte frame -> 10 data + 50 bytes 0x00 pad + 4 FCS matching a software CRC over 60 bytes; tx_en high 72 cycles; ready_o high only during the 10 data beats.
- Two 64-byte frames with valid_i always high -> exactly 12 cycles tx_en=0 between the last FCS byte of frame 1 and the first 0x55 of frame 2; no bytes lost or duplicated.
- Underrun: drop valid_i after 5 data bytes -> one cycle tx_en=1, tx_er=1, txd=0; underrun_o pulse; remaining bytes up to last_i consumed with tx_en=0; then IFG and a clean next frame.
- Randomized valid_i gaps before SFD (in IDLE) and random frame lengths 1..1500 with valid_i held during DATA -> all FCS match the reference model; tx_er never set.
- Assert reset_n_i low mid-DATA -> all outputs 0 asynchronously; after release, next frame starts with full preamble and correct FCS.
